pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_ctrl_match.sv | 61 ++++++
 rtl/pipe_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared types and constants for the pipeline controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam int unsigned c_REG_W  = 5;
  localparam int unsigned c_CNT_W  = 16;
  localparam int unsigned c_FWD_RF = 0;

  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

  typedef struct packed {
    logic               vld;
    logic [c_REG_W-1:0] rd;
    logic               wr;
    logic               load;
  } shadow_t;

  localparam shadow_t c_SHADOW_NULL = '0;

  // x0 is hard-wired, so a writer targeting it never creates a dependency.
  function automatic logic ent_hit(input shadow_t e, input logic [c_REG_W-1:0] rs,
                                   input logic rs_use);
    return e.vld && e.wr && (e.rd != '0) && (e.rd == rs) && rs_use;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_match.sv
// ============================================================================
// Module  : pipe_ctrl_match
// Brief   : Youngest-match search and ready check for one source operand.
//           Forwarding is enabled by defining PIPE_CTRL_FWD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_match
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES  = 5,
  parameter int ALU_RDY  = 1,
  parameter int LOAD_RDY = 3
) (
  input  logic                       vld,
  input  logic [c_REG_W-1:0]         rs,
  input  logic                       rs_use,
  input  shadow_t [NSTAGES-2:1]      ents,
  output logic [$clog2(NSTAGES)-1:0] fwd,
  output logic                       stall
);

  localparam int c_FWD_W = $clog2(NSTAGES);

`ifdef PIPE_CTRL_FWD_EN
  localparam bit c_FWD_ON = 1'b1;
`else
  localparam bit c_FWD_ON = 1'b0;
`endif

  // Without forwarding the threshold sits beyond the last register, so every hit stalls.
  localparam int c_ALU_THR  = c_FWD_ON ? ALU_RDY  : NSTAGES - 1;
  localparam int c_LOAD_THR = c_FWD_ON ? LOAD_RDY : NSTAGES - 1;

  logic               w_hit;
  logic               w_load;
  logic [c_FWD_W-1:0] w_k;
  logic               w_ready;

  always_comb begin
    w_hit  = 1'b0;
    w_load = 1'b0;
    w_k    = '0;
    // Scan oldest to youngest so the smallest index is the one left standing.
    for (int k = NSTAGES - 2; k >= 1; k--) begin
      if (ent_hit(ents[k], rs, rs_use)) begin
        w_hit  = 1'b1;
        w_load = ents[k].load;
        w_k    = c_FWD_W'(k);
      end
    end
  end

  assign w_ready = (int'(w_k) >= (w_load ? c_LOAD_THR : c_ALU_THR));
  assign fwd     = (vld && w_hit && w_ready) ? w_k : c_FWD_W'(c_FWD_RF);
  assign stall   = vld && w_hit && !w_ready;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module  : pipe_ctrl
// Brief   : In-order pipeline controller: hazard stall, flush, freeze and
//           operand forwarding. Optional macro: PIPE_CTRL_FWD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES  = 5,
  parameter int ALU_RDY  = 1,
  parameter int LOAD_RDY = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_busy,
  input  logic                       flush_req,
  input  logic                       id_vld,
  input  logic                       id_wr,
  input  logic                       id_load,
  input  logic [c_REG_W-1:0]         id_rs1,
  input  logic [c_REG_W-1:0]         id_rs2,
  input  logic [c_REG_W-1:0]         id_rd,
  input  logic                       id_rs1_use,
  input  logic                       id_rs2_use,
  output logic                       pc_en,
  output logic [NSTAGES-2:0]         st_en,
  output logic [NSTAGES-2:0]         st_kill,
  output logic [$clog2(NSTAGES)-1:0] fwd_rs1,
  output logic [$clog2(NSTAGES)-1:0] fwd_rs2,
  output logic                       hz_stall,
  output logic [c_CNT_W-1:0]         stall_cnt,
  output logic [c_CNT_W-1:0]         flush_cnt
);

  localparam int c_FWD_W = $clog2(NSTAGES);

  shadow_t [NSTAGES-2:1] r_shadow;
  logic [c_CNT_W-1:0]    r_stall_cnt;
  logic [c_CNT_W-1:0]    r_flush_cnt;

  shadow_t            w_id_ent;
  logic [c_FWD_W-1:0] w_fwd1;
  logic [c_FWD_W-1:0] w_fwd2;
  logic               w_stall1;
  logic               w_stall2;
  logic               w_flush_acc;

  assign w_id_ent = '{vld: id_vld, rd: id_rd, wr: id_wr, load: id_load};

  pipe_ctrl_match #(
    .NSTAGES  (NSTAGES),
    .ALU_RDY  (ALU_RDY),
    .LOAD_RDY (LOAD_RDY)
  ) u_match_rs1 (
    .vld    (id_vld),
    .rs     (id_rs1),
    .rs_use (id_rs1_use),
    .ents   (r_shadow),
    .fwd    (w_fwd1),
    .stall  (w_stall1)
  );

  pipe_ctrl_match #(
    .NSTAGES  (NSTAGES),
    .ALU_RDY  (ALU_RDY),
    .LOAD_RDY (LOAD_RDY)
  ) u_match_rs2 (
    .vld    (id_vld),
    .rs     (id_rs2),
    .rs_use (id_rs2_use),
    .ents   (r_shadow),
    .fwd    (w_fwd2),
    .stall  (w_stall2)
  );

  always_comb begin
    pc_en    = 1'b1;
    st_en    = '1;
    st_kill  = '0;
    hz_stall = 1'b0;
    fwd_rs1  = w_fwd1;
    fwd_rs2  = w_fwd2;
    if (!rst) begin
      pc_en   = 1'b0;
      st_en   = '0;
      st_kill = '1;
      fwd_rs1 = c_FWD_W'(c_FWD_RF);
      fwd_rs2 = c_FWD_W'(c_FWD_RF);
    end else if (mem_busy) begin
      pc_en = 1'b0;
      st_en = '0;
    end else if (flush_req) begin
      st_kill[1:0] = 2'b11;
    end else if (w_stall1 || w_stall2) begin
      // Hold IF/ID, drop a bubble into ID/EX, let the older stages drain.
      pc_en      = 1'b0;
      st_en[0]   = 1'b0;
      st_kill[1] = 1'b1;
      hz_stall   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shadow <= '0;
    end else begin
      if (st_en[1]) r_shadow[1] <= st_kill[1] ? c_SHADOW_NULL : w_id_ent;
      for (int k = 2; k <= NSTAGES - 2; k++) begin
        if (st_en[k]) r_shadow[k] <= st_kill[k] ? c_SHADOW_NULL : r_shadow[k-1];
      end
    end
  end

  assign w_flush_acc = flush_req && !mem_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (hz_stall && (r_stall_cnt != c_CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_acc && (r_flush_cnt != c_CNT_MAX)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire
